hazard_ctl: RTL
===============

Name: hazard_ctl

Overview:
- Pipeline hazard and stall controller. It generates the clock-enable and flush controls for the IF/ID, ID/EX and EX/MEM pipeline registers.
- Sources handled:
  - load-use data hazards (D vs E)
  - taken branch/jump redirects (E)
  - multi-cycle data-memory waits (M)
  - exceptions/mret raised in M
- It sits beside the datapath and drives every pipeline register's i_clk_en / flush inputs, including i_id_ex_flush and i_id_ex_flush_exception_m.

Parameters:
- MEM_TIMEOUT, 64, max wait cycles for i_dmem_ready_m before a bus error is flagged (2..65535)
- TRAP_FLUSH_CYCLES, 2, cycles all front-end registers are held flushed after a trap/mret (1..7)

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_rs1_d  in  5  rs1 of instruction in D
- i_rs2_d  in  5  rs2 of instruction in D
- i_rd_e  in  5  rd of instruction in E
- i_result_src_e  in  2  result select in E; 2'b01 = load
- i_reg_wr_e  in  1  E instruction writes register file
- i_pc_src_e  in  1  taken branch or jump resolved in E
- i_mem_access_m  in  1  M instruction accesses data memory
- i_dmem_ready_m  in  1  data memory completes access this cycle
- i_exception_m  in  1  exception (incl. ecall) detected in M
- i_mret_m  in  1  mret in M
- o_pc_en  out  1  PC register enable
- o_if_id_clk_en  out  1  IF/ID enable
- o_if_id_flush  out  1  IF/ID flush
- o_id_ex_clk_en  out  1  ID/EX enable
- o_id_ex_flush  out  1  ID/EX flush (hazard bubble / redirect)
- o_id_ex_flush_exception_m  out  1  ID/EX flush due to trap
- o_ex_mem_clk_en  out  1  EX/MEM enable
- o_ex_mem_flush  out  1  EX/MEM flush
- o_trap_redirect  out  1  one-cycle pulse: PC loads mtvec/mepc
- o_bus_err  out  1  sticky memory-timeout error
- o_stall_cnt  out  32  saturating count of cycles with o_pc_en=0

Behaviour:
- Reset (i_rst=1 at posedge, wins over everything):
  - FSM=RUN, wait/flush counters=0, o_bus_err=0, o_stall_cnt=0.
  - Outputs during and after reset follow RUN with all inputs decoded.
- FSM states: RUN, MEM_WAIT, TRAP_FLUSH. Outputs are combinational from state plus current inputs; state and counters update on posedge.
- Priority within a cycle: exception/mret > mem wait > redirect > load-use.
- RUN:
  - **Trap:** i_exception_m or i_mret_m → o_trap_redirect=1; flush IF/ID, ID/EX (o_id_ex_flush_exception_m=1) and EX/MEM; o_pc_en=1. Next state TRAP_FLUSH, flush_cnt=TRAP_FLUSH_CYCLES-1. If TRAP_FLUSH_CYCLES=1, stay RUN.
  - **Memory wait:** i_mem_access_m && !i_dmem_ready_m → o_pc_en, o_if_id_clk_en, o_id_ex_clk_en, o_ex_mem_clk_en all 0; no flushes. Next state MEM_WAIT, wait_cnt=1.
  - **Redirect:** i_pc_src_e → o_if_id_flush=1, o_id_ex_flush=1, all enables 1.
  - **Load-use:** i_result_src_e==2'b01 && i_reg_wr_e && i_rd_e!=0 && (i_rd_e==i_rs1_d || i_rd_e==i_rs2_d) → o_pc_en=0, o_if_id_clk_en=0, o_id_ex_flush=1, EX/MEM enabled.
    - Lasts exactly 1 cycle: the load moves to M, the bubble is in E.
  - Otherwise: all enables 1, all flushes 0, o_trap_redirect=0.
- MEM_WAIT:
  - All four enables 0; wait_cnt increments each cycle.
  - i_dmem_ready_m=1 → enables 1 this cycle, return to RUN. Load-use/redirect are evaluated normally in that same cycle.
  - wait_cnt reaches MEM_TIMEOUT → o_bus_err set (sticky until reset); treat as ready and return to RUN.
  - i_exception_m during MEM_WAIT is handled as the RUN trap case and preempts the wait.
- TRAP_FLUSH:
  - o_if_id_flush=1, o_id_ex_flush_exception_m=1, o_ex_mem_flush=1; PC enabled; o_trap_redirect=0.
  - flush_cnt decrements; at 0 → RUN.
  - A new exception/mret in this state re-issues o_trap_redirect and reloads flush_cnt.
- o_stall_cnt: +1 every cycle o_pc_en=0; saturates at 32'hFFFF_FFFF.
- Enable and flush for the same register may both be 1; the flush dominates at the register.

Test Plan:
- Reset → next cycle all enables=1, flushes=0, o_bus_err=0, o_stall_cnt=0, state RUN.
- Load-use: i_result_src_e=01, i_reg_wr_e=1, i_rd_e=5, i_rs2_d=5 for 1 cycle → o_pc_en=0, o_if_id_clk_en=0, o_id_ex_flush=1 for exactly 1 cycle, o_stall_cnt=1. Same stimulus with i_rd_e=0 → no stall.
- Taken branch: i_pc_src_e=1 → o_if_id_flush=o_id_ex_flush=1, o_pc_en=1. With a simultaneous load-use condition, the flushes win and o_pc_en=1.
- Memory wait: i_mem_access_m=1, i_dmem_ready_m=0 for 3 cycles then 1 → enables 0 for 3 cycles, 1 on the 4th, o_stall_cnt=3. With MEM_TIMEOUT=4 and ready held 0 → o_bus_err=1 after 4 cycles, pipeline resumes.
- Exception while a branch is taken → o_trap_redirect=1 for one cycle, then all three flushes held for TRAP_FLUSH_CYCLES=2 cycles total, no o_id_ex_flush from the branch path.
- Reset asserted mid MEM_WAIT → next cycle state RUN, o_bus_err=0, counters 0.

Source files
------------

// File: rtl/hazard_ctl.sv
// Pipeline hazard and stall controller.
// Drives the clock-enable and flush inputs of the IF/ID, ID/EX and EX/MEM
// pipeline registers. It handles load-use hazards, taken branch redirects,
// multi-cycle data-memory waits, and traps (exceptions and mret) raised in M.
module hazard_ctl #(
    parameter int MEM_TIMEOUT       = 64,
    parameter int TRAP_FLUSH_CYCLES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [4:0]  i_rs1_d,
    input  logic [4:0]  i_rs2_d,
    input  logic [4:0]  i_rd_e,
    input  logic [1:0]  i_result_src_e,
    input  logic        i_reg_wr_e,
    input  logic        i_pc_src_e,
    input  logic        i_mem_access_m,
    input  logic        i_dmem_ready_m,
    input  logic        i_exception_m,
    input  logic        i_mret_m,
    output logic        o_pc_en,
    output logic        o_if_id_clk_en,
    output logic        o_if_id_flush,
    output logic        o_id_ex_clk_en,
    output logic        o_id_ex_flush,
    output logic        o_id_ex_flush_exception_m,
    output logic        o_ex_mem_clk_en,
    output logic        o_ex_mem_flush,
    output logic        o_trap_redirect,
    output logic        o_bus_err,
    output logic [31:0] o_stall_cnt
);

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_MEM_WAIT   = 2'd1,
        ST_TRAP_FLUSH = 2'd2
    } state_t;

    localparam logic [15:0] TIMEOUT_LIMIT = 16'(MEM_TIMEOUT);
    localparam logic [2:0]  FLUSH_RELOAD  = 3'(TRAP_FLUSH_CYCLES - 1);

    state_t      r_state;
    state_t      w_state;
    state_t      w_nextState;
    logic [15:0] r_waitCnt;
    logic [15:0] w_waitCntNext;
    logic [2:0]  r_flushCnt;
    logic [2:0]  w_flushCntNext;
    logic        r_busErr;
    logic        w_setBusErr;
    logic [31:0] r_stallCnt;

    logic        w_trap;
    logic        w_loadUse;
    logic        w_timeout;
    logic        w_memBlock;

    // Hazard terms; while reset is held the outputs decode as if in RUN
    always_comb begin
        w_state    = i_rst ? ST_RUN : r_state;
        w_trap     = i_exception_m | i_mret_m;
        w_loadUse  = (i_result_src_e == 2'b01) && i_reg_wr_e && (i_rd_e != 5'd0) &&
                     ((i_rd_e == i_rs1_d) || (i_rd_e == i_rs2_d));
        w_timeout  = (w_state == ST_MEM_WAIT) && !i_dmem_ready_m && (r_waitCnt >= TIMEOUT_LIMIT);
        w_memBlock = 1'b0;
        if (w_state == ST_RUN) begin
            w_memBlock = i_mem_access_m && !i_dmem_ready_m;
        end else if (w_state == ST_MEM_WAIT) begin
            w_memBlock = !i_dmem_ready_m && !w_timeout;
        end
    end

    // Next-state and output decode, highest priority source first
    always_comb begin
        o_pc_en                   = 1'b1;
        o_if_id_clk_en            = 1'b1;
        o_if_id_flush             = 1'b0;
        o_id_ex_clk_en            = 1'b1;
        o_id_ex_flush             = 1'b0;
        o_id_ex_flush_exception_m = 1'b0;
        o_ex_mem_clk_en           = 1'b1;
        o_ex_mem_flush            = 1'b0;
        o_trap_redirect           = 1'b0;
        w_nextState               = w_state;
        w_waitCntNext             = r_waitCnt;
        w_flushCntNext            = r_flushCnt;
        w_setBusErr               = 1'b0;

        if (w_trap) begin
            o_trap_redirect           = 1'b1;
            o_if_id_flush             = 1'b1;
            o_id_ex_flush_exception_m = 1'b1;
            o_ex_mem_flush            = 1'b1;
            w_waitCntNext             = 16'd0;
            if (TRAP_FLUSH_CYCLES > 1) begin
                w_nextState    = ST_TRAP_FLUSH;
                w_flushCntNext = FLUSH_RELOAD;
            end else begin
                w_nextState    = ST_RUN;
                w_flushCntNext = 3'd0;
            end
        end else if (w_state == ST_TRAP_FLUSH) begin
            o_if_id_flush             = 1'b1;
            o_id_ex_flush_exception_m = 1'b1;
            o_ex_mem_flush            = 1'b1;
            if (r_flushCnt <= 3'd1) begin
                w_nextState    = ST_RUN;
                w_flushCntNext = 3'd0;
            end else begin
                w_flushCntNext = r_flushCnt - 3'd1;
            end
        end else if (w_memBlock) begin
            o_pc_en         = 1'b0;
            o_if_id_clk_en  = 1'b0;
            o_id_ex_clk_en  = 1'b0;
            o_ex_mem_clk_en = 1'b0;
            w_nextState     = ST_MEM_WAIT;
            w_waitCntNext   = (w_state == ST_RUN) ? 16'd1 : 16'(r_waitCnt + 16'd1);
        end else begin
            w_nextState   = ST_RUN;
            w_waitCntNext = 16'd0;
            w_setBusErr   = w_timeout;
            if (i_pc_src_e) begin
                o_if_id_flush = 1'b1;
                o_id_ex_flush = 1'b1;
            end else if (w_loadUse) begin
                o_pc_en        = 1'b0;
                o_if_id_clk_en = 1'b0;
                o_id_ex_flush  = 1'b1;
            end
        end
    end

    // State, counters, sticky bus error and saturating stall counter
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_RUN;
            r_waitCnt  <= 16'd0;
            r_flushCnt <= 3'd0;
            r_busErr   <= 1'b0;
            r_stallCnt <= 32'd0;
        end else begin
            r_state    <= w_nextState;
            r_waitCnt  <= w_waitCntNext;
            r_flushCnt <= w_flushCntNext;
            r_busErr   <= r_busErr | w_setBusErr;
            if (!o_pc_en && (r_stallCnt != 32'hFFFF_FFFF)) begin
                r_stallCnt <= r_stallCnt + 32'd1;
            end
        end
    end

    assign o_bus_err   = r_busErr;
    assign o_stall_cnt = r_stallCnt;

endmodule
